// File: rtl/muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide unit: op encoding, FSM states,
// iteration count and a magnitude helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_ITER = 32;
  localparam int CNT_W       = 5;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Operand magnitude latch, 64-bit shift register and one radix-2 step
// (shift-add multiply / restoring divide). MULDIV_FAST_MUL_EN: single-step multiply.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        div_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [63:0] p_nxt,
  output logic        b_zero
);

  logic [31:0] a_q, b_q;
  logic        div_q;
  logic [63:0] p_q;
  logic [32:0] rem_sh, diff;
`ifndef MULDIV_FAST_MUL_EN
  logic [32:0] sum;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      p_q   <= '0;
    end else if (load) begin
      a_q   <= a_in;
      b_q   <= b_in;
      div_q <= div_in;
      // divide: {remainder, dividend}; multiply: {partial sum, multiplier}
      p_q   <= div_in ? {32'd0, a_in} : {32'd0, b_in};
    end else if (step) begin
      p_q   <= p_nxt;
    end
  end

  always_comb begin
    rem_sh = p_q[63:31];
    diff   = rem_sh - {1'b0, b_q};
`ifndef MULDIV_FAST_MUL_EN
    sum    = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, a_q} : 33'd0);
`endif
    if (div_q)
      p_nxt = diff[32] ? {p_q[62:0], 1'b0} : {diff[31:0], p_q[30:0], 1'b1};
    else
`ifdef MULDIV_FAST_MUL_EN
      p_nxt = {32'd0, a_q} * {32'd0, b_q};
`else
      p_nxt = {sum, p_q[31:1]};
`endif
  end

  assign b_zero = (b_q == 32'd0);

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning HI/LO; stalls the front end while busy.
// MULDIV_FAST_MUL_EN: MULT/MULTU finish in one BUSY cycle.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  muldiv_op_t  op_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        ex_stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  muldiv_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q, lo_q, rs_q;
  logic             div_q, q_neg, r_neg;

  logic        is_md, is_div, is_sgn, start, fin, b_zero;
  logic [31:0] a_in, b_in, quot, rem, res_hi, res_lo;
  logic [63:0] p_nxt, prod;

  assign is_md  = (op_i == OP_MULT) || (op_i == OP_MULTU) ||
                  (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign is_div = (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign is_sgn = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign start  = (state == S_IDLE) && is_md && !flush_i;
  assign a_in   = mag32(rs_data_i, is_sgn);
  assign b_in   = mag32(rt_data_i, is_sgn);

  muldiv_iter u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (start),
    .step   (state == S_BUSY),
    .div_in (is_div),
    .a_in   (a_in),
    .b_in   (b_in),
    .p_nxt  (p_nxt),
    .b_zero (b_zero)
  );

`ifdef MULDIV_FAST_MUL_EN
  assign fin = (state == S_BUSY) && ((cnt == CNT_W'(MULDIV_ITER - 1)) || !div_q);
`else
  assign fin = (state == S_BUSY) && (cnt == CNT_W'(MULDIV_ITER - 1));
`endif

  // Sign fix-up applied to the step output so HI/LO land on the final edge
  always_comb begin
    prod = q_neg ? (~p_nxt + 64'd1) : p_nxt;
    quot = p_nxt[31:0];
    rem  = p_nxt[63:32];
    if (!div_q) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (b_zero) begin
      res_hi = rs_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = r_neg ? (~rem + 32'd1) : rem;
      res_lo = q_neg ? (~quot + 32'd1) : quot;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      rs_q  <= '0;
      div_q <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rs_q  <= rs_data_i;
            div_q <= is_div;
            q_neg <= is_sgn && (rs_data_i[31] ^ rt_data_i[31]);
            r_neg <= (op_i == OP_DIV) && rs_data_i[31];
            cnt   <= '0;
            state <= S_BUSY;
          end else if (!flush_i) begin
            if (op_i == OP_MTHI) hi_q <= rs_data_i;
            if (op_i == OP_MTLO) lo_q <= rs_data_i;
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (fin) begin
              hi_q  <= res_hi;
              lo_q  <= res_lo;
              state <= S_DONE;
            end
          end
        end
        // Hold here while EX is held so the same instruction cannot restart
        S_DONE: if (flush_i || !stall_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ex_stall_o = !flush_i && (start || (state == S_BUSY));
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: vector table through a HI/LO scoreboard plus
// hand-written hold, flush, move and reset sequences.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  muldiv_op_t  op_i = OP_NONE;
  logic [31:0] rs_data_i = '0, rt_data_i = '0;
  logic        stall_i = 1'b0, flush_i = 1'b0;
  logic        ex_stall_o;
  logic [31:0] hi_o, lo_o;

  ex_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .op_i       (op_i),
    .rs_data_i  (rs_data_i),
    .rt_data_i  (rt_data_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .ex_stall_o (ex_stall_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] rs, rt, hi, lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   total = 0, passed = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_CYC = 2;
`else
  localparam int MUL_CYC = 33;
`endif
  localparam int DIV_CYC = 33;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive in the cycle after an edge, wait out the stall, compare against the scoreboard.
  task automatic do_op(input muldiv_op_t op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ehi, input logic [31:0] elo, input int ecyc,
                       input logic hold);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    op_i = op; rs_data_i = rs; rt_data_i = rt; stall_i = hold;
    sb.push_back('{hi: ehi, lo: elo});
    #1;
    n = 0;
    while (ex_stall_o && n < 100) begin
      n++;
      @(posedge clk); #1;
      if (!hold) op_i = OP_NONE;
      #1;
    end
    check($sformatf("stall_cycles op%0d", op), 32'(n), 32'(ecyc));
    e = sb.pop_front();
    check($sformatf("hi op%0d rs=%h rt=%h", op, rs, rt), hi_o, e.hi);
    check($sformatf("lo op%0d rs=%h rt=%h", op, rs, rt), lo_o, e.lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[1]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2]  = '{OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    vecs[3]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4]  = '{OP_MULT,  32'h0000_0003, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4};
    vecs[5]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[6]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[9]  = '{OP_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
    vecs[10] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};

    // reset state
    #3;
    check("reset hi", hi_o, 32'h0);
    check("reset lo", lo_o, 32'h0);
    check("reset stall", 32'(ex_stall_o), 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // MTHI / MTLO: no stall, visible next cycle
    @(posedge clk); #1 op_i = OP_MTHI; rs_data_i = 32'hDEAD_BEEF; #1;
    check("mthi stall", 32'(ex_stall_o), 32'h0);
    @(posedge clk); #1 op_i = OP_MTLO; rs_data_i = 32'hCAFE_F00D; #1;
    check("mthi hi", hi_o, 32'hDEAD_BEEF);
    check("mtlo stall", 32'(ex_stall_o), 32'h0);
    @(posedge clk); #1 op_i = OP_NONE; #1;
    check("mtlo lo", lo_o, 32'hCAFE_F00D);
    check("mtlo hi kept", hi_o, 32'hDEAD_BEEF);

    // hold after completion: op and stall_i stay asserted, no restart
    do_op(OP_DIVU, 32'd1000, 32'd10, 32'd0, 32'd100, DIV_CYC, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check($sformatf("hold stall c%0d", i), 32'(ex_stall_o), 32'h0);
      check($sformatf("hold lo c%0d", i), lo_o, 32'd100);
    end
    check("hold hi", hi_o, 32'd0);
    @(posedge clk); #1 stall_i = 1'b0; op_i = OP_NONE;

    // flush at C+10 of a DIV
    @(posedge clk); #1 op_i = OP_DIV; rs_data_i = 32'd1000; rt_data_i = 32'd3; #1;
    check("flush div start stall", 32'(ex_stall_o), 32'h1);
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1 op_i = OP_NONE; end
    flush_i = 1'b1; #1;
    check("flush cycle stall", 32'(ex_stall_o), 32'h0);
    @(posedge clk); #1 flush_i = 1'b0; #1;
    check("post flush stall", 32'(ex_stall_o), 32'h0);
    repeat (35) @(posedge clk);
    #2;
    check("post flush lo", lo_o, 32'd100);
    check("post flush hi", hi_o, 32'd0);

    // flush and start in the same cycle
    @(posedge clk); #1 op_i = OP_DIVU; rs_data_i = 32'd5; rt_data_i = 32'd1; flush_i = 1'b1; #1;
    check("flush+start stall", 32'(ex_stall_o), 32'h0);
    @(posedge clk); #1 op_i = OP_NONE; flush_i = 1'b0; #1;
    check("flush+start next stall", 32'(ex_stall_o), 32'h0);
    repeat (35) @(posedge clk);
    #2;
    check("flush+start lo", lo_o, 32'd100);

    // reset mid-MULT
    @(posedge clk); #1 op_i = OP_MTHI; rs_data_i = 32'h1357_9BDF;
    @(posedge clk); #1 op_i = OP_MULT; rs_data_i = 32'd5; rt_data_i = 32'd6;
    @(posedge clk); #1 op_i = OP_NONE;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0; #1;
    check("rst mid hi", hi_o, 32'h0);
    check("rst mid lo", lo_o, 32'h0);
    check("rst mid stall", 32'(ex_stall_o), 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // table of vectors, back to back
    for (int i = 0; i < 12; i++)
      do_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo,
            ((vecs[i].op == OP_MULT) || (vecs[i].op == OP_MULTU)) ? MUL_CYC : DIV_CYC, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
